// File: rtl/switch_arb.sv
// switch_arb: round-robin, burst-bounded, stall-aware two-requester arbiter that
// registers the accepted beat onto the shared switch input.
module switch_arb #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = 8'h3F,
  parameter int                    MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_vld,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_rdy,
  input  logic                  req1_vld,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_rdy,
  input  logic                  stall_a,
  input  logic                  stall_b,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  gnt_id
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, vld_q, gnt_id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  elig0, elig1, own, elig_own, elig_oth, gnt_vld, gnt;
  // A requester whose destination port is stalled is simply not a candidate.
  assign elig0 = req0_vld && !((req0_addr > ADDR_DIV) ? stall_b : stall_a);
  assign elig1 = req1_vld && !((req1_addr > ADDR_DIV) ? stall_b : stall_a);
  always_comb begin
    own      = (state_q == OWN1);
    elig_own = own ? elig1 : elig0;
    elig_oth = own ? elig0 : elig1;
    gnt_vld  = 1'b0;
    gnt      = own;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      gnt_vld = elig0 | elig1;
      gnt     = (elig0 & elig1) ? ~last_q : elig1;
      cnt_d   = gnt_vld ? CW'(1) : cnt_q;
    end else if (elig_own && cnt_q < CW'(MAX_BURST)) begin
      gnt_vld = 1'b1;
      cnt_d   = cnt_q + CW'(1);
    end else if (elig_oth) begin
      gnt_vld = 1'b1;
      gnt     = ~own;
      cnt_d   = CW'(1);
    end else if (elig_own) begin
      gnt_vld = 1'b1;
      cnt_d   = CW'(1);
    end
    state_d = gnt_vld ? (gnt ? OWN1 : OWN0) : IDLE;
  end
  assign req0_rdy = rstn & gnt_vld & ~gnt;
  assign req1_rdy = rstn & gnt_vld & gnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      vld_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      gnt_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= gnt_vld;
      addr_q   <= gnt_vld ? (gnt ? req1_addr : req0_addr) : '0;
      data_q   <= gnt_vld ? (gnt ? req1_data : req0_data) : '0;
      if (gnt_vld) last_q   <= gnt;
      if (gnt_vld) gnt_id_q <= gnt;
    end
  end
  assign vld    = vld_q;
  assign addr   = addr_q;
  assign data   = data_q;
  assign gnt_id = gnt_id_q;
endmodule

// File: tb/tb_switch_arb.sv
// tb_switch_arb: directed checks of switch_arb handshake, arbitration and reset.
module tb_switch_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [7:0]  req0_addr, req1_addr, addr;
  logic [15:0] req0_data, req1_data, data;
  logic        stall_a, stall_b, vld, gnt_id;
  int          tests = 0;
  int          fails = 0;
  logic        e;

  switch_arb dut (
    .clk(clk), .rstn(rstn),
    .req0_vld(req0_vld), .req0_addr(req0_addr), .req0_data(req0_data), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_addr(req1_addr), .req1_data(req1_data), .req1_rdy(req1_rdy),
    .stall_a(stall_a), .stall_b(stall_b),
    .vld(vld), .addr(addr), .data(data), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    req0_vld = 1'b1; req0_addr = 8'h10; req0_data = '0;
    req1_vld = 1'b0; req1_addr = '0;    req1_data = '0;
    #3;
    chk("rst_rdy0", 32'(req0_rdy), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    cyc();
    cyc();
    rstn = 1'b1;
    // contention: runs of 4, requester 0 first
    req0_vld = 1'b1; req0_addr = 8'h01; req0_data = 16'hA001;
    req1_vld = 1'b1; req1_addr = 8'h02; req1_data = 16'hB002;
    for (int i = 0; i < 12; i++) begin
      e = 1'((i / 4) % 2);
      #1;
      chk("cont_rdy0", 32'(req0_rdy), 32'(!e));
      chk("cont_rdy1", 32'(req1_rdy), 32'(e));
      cyc();
      chk("cont_gnt", 32'(gnt_id), 32'(e));
      chk("cont_vld", 32'(vld), 1);
      chk("cont_data", 32'(data), e ? 'hB002 : 'hA001);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    cyc();
    chk("cont_end_vld", 32'(vld), 0);
    // single requester back-to-back, then owner drop
    req0_vld = 1'b1; req0_addr = 8'h10; req0_data = 16'h1111;
    #1;
    chk("sgl_rdy0a", 32'(req0_rdy), 1);
    chk("sgl_rdy1a", 32'(req1_rdy), 0);
    cyc();
    chk("sgl_vld1", 32'(vld), 1);
    chk("sgl_addr1", 32'(addr), 'h10);
    chk("sgl_data1", 32'(data), 'h1111);
    chk("sgl_gnt1", 32'(gnt_id), 0);
    req0_addr = 8'h50; req0_data = 16'h2222;
    #1;
    chk("sgl_rdy0b", 32'(req0_rdy), 1);
    cyc();
    chk("sgl_vld2", 32'(vld), 1);
    chk("sgl_addr2", 32'(addr), 'h50);
    chk("sgl_data2", 32'(data), 'h2222);
    chk("sgl_gnt2", 32'(gnt_id), 0);
    req0_vld = 1'b0;
    #1;
    chk("drop_rdy0", 32'(req0_rdy), 0);
    cyc();
    chk("drop_vld", 32'(vld), 0);
    chk("drop_addr", 32'(addr), 0);
    chk("drop_data", 32'(data), 0);
    chk("drop_gnt_hold", 32'(gnt_id), 0);
    // port B stalled for 3 cycles: req1 (A) proceeds, req0 (B) after req1 burst ends
    req0_vld = 1'b1; req0_addr = 8'h80; req0_data = 16'hC0C0;
    req1_vld = 1'b1; req1_addr = 8'h20; req1_data = 16'hD1D1;
    for (int i = 0; i < 5; i++) begin
      stall_b = (i < 3);
      e = (i != 4);
      #1;
      chk("stall_rdy0", 32'(req0_rdy), 32'(!e));
      chk("stall_rdy1", 32'(req1_rdy), 32'(e));
      cyc();
      chk("stall_gnt", 32'(gnt_id), 32'(e));
      chk("stall_addr", 32'(addr), e ? 'h20 : 'h80);
    end
    req0_vld = 1'b0; req1_vld = 1'b0; stall_b = 1'b0;
    cyc();
    chk("stall_end_vld", 32'(vld), 0);
    // boundary address: 3F is port A, 40 is port B
    stall_a = 1'b1;
    req0_vld = 1'b1; req0_addr = 8'h3F; req0_data = 16'h3F3F;
    #1;
    chk("bnd_3f_rdy0", 32'(req0_rdy), 0);
    cyc();
    chk("bnd_3f_vld", 32'(vld), 0);
    req0_addr = 8'h40;
    #1;
    chk("bnd_40_rdy0", 32'(req0_rdy), 1);
    cyc();
    chk("bnd_40_vld", 32'(vld), 1);
    chk("bnd_40_addr", 32'(addr), 'h40);
    req0_vld = 1'b0; stall_a = 1'b0;
    cyc();
    // async reset during third beat of a req1 burst
    req1_vld = 1'b1; req1_addr = 8'h30; req1_data = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rb_rdy1", 32'(req1_rdy), 1);
      cyc();
    end
    chk("rb_gnt_pre", 32'(gnt_id), 1);
    chk("rb_vld_pre", 32'(vld), 1);
    #1;
    chk("rb_rdy1_3rd", 32'(req1_rdy), 1);
    #1 rstn = 1'b0;
    #1;
    chk("rb_vld", 32'(vld), 0);
    chk("rb_addr", 32'(addr), 0);
    chk("rb_data", 32'(data), 0);
    chk("rb_gnt", 32'(gnt_id), 0);
    chk("rb_rdy1", 32'(req1_rdy), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    req0_vld = 1'b1; req0_addr = 8'h07; req0_data = 16'h7777;
    #1;
    chk("post_rdy0", 32'(req0_rdy), 1);
    chk("post_rdy1", 32'(req1_rdy), 0);
    cyc();
    chk("post_gnt", 32'(gnt_id), 0);
    chk("post_vld", 32'(vld), 1);
    chk("post_addr", 32'(addr), 'h07);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_arb.md
# switch_arb

Two-requester arbiter that shares the single `vld`/`addr`/`data` input of the address-split switch between two upstream masters. It accepts at most one beat per cycle using a valid/ready handshake and registers that beat onto the switch input. Arbitration is round-robin with a bounded burst length. A requester is skipped while the switch output port its address targets is stalled, so one blocked destination does not hold up traffic to the other.

## Interface
- `ADDR_WIDTH`, 8, address width; must match the switch.
- `DATA_WIDTH`, 16, data width; must match the switch.
- `ADDR_DIV`, 8'h3F, port-A/port-B split; addr <= ADDR_DIV targets A, otherwise B. Must match the switch.
- `MAX_BURST`, 4, maximum consecutive beats granted to one requester while the other is eligible; >= 1.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req0_vld` in 1: requester 0 has a beat.
- `req0_addr` in ADDR_WIDTH: requester 0 address.
- `req0_data` in DATA_WIDTH: requester 0 data.
- `req0_rdy` out 1: beat from requester 0 accepted this cycle; combinational.
- `req1_vld`, `req1_addr`, `req1_data`, `req1_rdy`: same as requester 0, for requester 1.
- `stall_a` in 1: switch port A destination cannot accept.
- `stall_b` in 1: switch port B destination cannot accept.
- `vld` out 1: registered beat valid, to switch `vld`.
- `addr` out ADDR_WIDTH: registered address, to switch `addr`.
- `data` out DATA_WIDTH: registered data, to switch `data`.
- `gnt_id` out 1: requester that sourced the current `vld` beat.

## Operation
- Destination of requester N: A if `reqN_addr` <= ADDR_DIV (unsigned compare), else B.
- Eligibility: `eligN` = `reqN_vld` && !stall of the destination. Stall is sampled in the same cycle as the transfer.
- Transfer: `reqN_vld` && `reqN_rdy`. At most one `rdy` is high per cycle. `rdy` is never high without `vld`.
- Requesters hold `vld`, `addr` and `data` stable until `rdy` is high. A requester may drop `vld` before it is accepted.
- Registers:
  - state ∈ {IDLE, OWN0, OWN1};
  - `burst_cnt`, width $clog2(MAX_BURST+1);
  - `last`, 1 bit: id of the last granted requester.
- IDLE:
  - both eligible: grant the requester != `last`;
  - one eligible: grant it;
  - after a grant: state -> OWNx, `burst_cnt` = 1;
  - none eligible: stay in IDLE.
- OWNx, evaluated in priority order:
  1. `eligx` && `burst_cnt` < MAX_BURST: grant x, `burst_cnt`++.
  2. Other requester eligible: grant other, state -> OWNother, `burst_cnt` = 1.
  3. `eligx` (burst exhausted, other idle): grant x, `burst_cnt` = 1.
  4. Otherwise: no grant, state -> IDLE.
- Every grant sets `last` to the granted id.
- Output register, on the clock edge after a transfer: `vld` = 1, `addr`/`data` = accepted values, `gnt_id` = granted id. With no transfer: `vld` = 0, `addr` = 0, `data` = 0, `gnt_id` holds its value.
- Reset values: `vld` = 0, `addr` = 0, `data` = 0, `gnt_id` = 0, state = IDLE, `burst_cnt` = 0, `last` = 1, so requester 0 wins the first contention. `reqN_rdy` = 0 while `rstn` is low.

## Timing
- Handshake to `vld` high: 1 cycle. The switch adds 1 more, so the beat appears on `addr_a/b` 2 cycles after the accepting edge.
- Throughput: 1 beat per cycle, including across requester switches. No bubble when handing off between OWN0 and OWN1.
- Fairness: with both requesters continuously eligible, grants alternate in runs of exactly MAX_BURST. MAX_BURST = 1 gives strict alternation.
- A stall asserting mid-burst ends the owner's eligibility in that same cycle; the other requester is granted in that cycle if eligible.
- Asynchronous reset mid-burst: all registers clear immediately. A beat accepted on the edge coinciding with reset assertion is dropped. The first grant after reset release is possible on the first rising edge with `rstn` high.

## Test plan
- Single requester: req0 sends addr 8'h10, 8'h50, data 16'h1111, 16'h2222 back-to-back, req1 idle. Required: `rdy0` high both cycles; `vld`/`addr`/`data` show 10/1111 then 50/2222 one cycle later; `gnt_id` = 0.
- Contention, MAX_BURST = 4: both requesters continuously valid, addr 8'h01 and 8'h02, 12 beats. Required: `gnt_id` sequence 0000 1111 0000, no idle cycle.
- Destination stall: req0 addr 8'h80 (B), req1 addr 8'h20 (A), `stall_b` = 1 for 3 cycles. Required: only req1 accepted during the stall; req0 accepted on the first cycle `stall_b` = 0, provided the burst/rr rules select it.
- Boundary address: req0 addr = 8'h3F with `stall_a` = 1, `stall_b` = 0. Required: no accept. Then addr = 8'h40: accepted the same cycle.
- Owner drops: OWN0 with `burst_cnt` = 2, req0 deasserts, req1 idle. Required: state -> IDLE, `vld` = 0 and `addr`/`data` = 0 on the next cycle.
- Reset mid-burst: assert `rstn` low asynchronously during the third beat of a burst. Required: `vld`/`addr`/`data` go to 0 immediately and `rdy` goes low. After release with both requesters eligible, the first `gnt_id` is 0.
